pipelined_carry_skip_adder: RTL and testbench

//   Parametrised N-bit carry-skip adder: WIDTH/BLK ripple blocks, each with a skip mux.

---
 rtl/pipelined_carry_skip_adder.sv | 116 +++++++++++
 tb/tb_pipelined_carry_skip_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_skip_adder.sv
// Two-stage pipelined carry-skip adder (WIDTH/BLK ripple blocks, each with a skip mux).
// Define CSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_carry_skip_adder #(
    parameter int  WIDTH = 16,
    parameter int  BLK   = 4,
    localparam int NB    = WIDTH / BLK,
    localparam int SKW   = $clog2(WIDTH / BLK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [SKW-1:0]   skip_hits
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // S1 empties into S2 whenever S2 is empty or its result is being taken,
    // so in_ready may follow out_ready combinationally in the same cycle.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic             s1_accept;
    logic             s2_load;

    assign s2_load   = s1_valid && (!out_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign s1_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
        end else if (s1_accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_cin   <= cin;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Skip chain over the S1 operands.
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [NB:0]      blk_c;
    logic [NB-1:0]    blk_p;
    logic [WIDTH-1:0] sum_c;
    logic [SKW-1:0]   hits_c;
    logic             rip;

    assign prop = s1_a ^ s1_b;
    assign gen  = s1_a & s1_b;

    always_comb begin
        blk_c    = '0;
        blk_p    = '0;
        sum_c    = '0;
        hits_c   = '0;
        rip      = 1'b0;
        blk_c[0] = s1_cin;
        for (int k = 0; k < NB; k++) begin
            rip = blk_c[k];
            for (int i = 0; i < BLK; i++) begin
                sum_c[k*BLK+i] = prop[k*BLK+i] ^ rip;
                rip            = gen[k*BLK+i] | (prop[k*BLK+i] & rip);
            end
            // Sum bits always come from the ripple adders; only the carry may skip.
            blk_p[k]     = &prop[k*BLK +: BLK];
            blk_c[k+1]   = blk_p[k] ? blk_c[k] : rip;
            hits_c       = hits_c + SKW'(blk_p[k]);
        end
    end

`ifdef CSA_OVERFLOW_EN
    logic ovf_c;
    assign ovf_c = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_c[WIDTH-1] != s1_a[WIDTH-1]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            skip_hits <= '0;
`ifdef CSA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else if (s2_load) begin
            out_valid <= 1'b1;
            sum       <= sum_c;
            cout      <= blk_c[NB];
            skip_hits <= hits_c;
`ifdef CSA_OVERFLOW_EN
            ovf       <= ovf_c;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Directed bench for pipelined_carry_skip_adder (WIDTH=16, BLK=4) with an in-order scoreboard.
module tb_pipelined_carry_skip_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic [2:0]  skip_hits;
    logic        ovf_o;

    int tests_run = 0;
    int fail_cnt  = 0;
    int rx_cnt    = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs;

    pipelined_carry_skip_adder #(.WIDTH(16), .BLK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .skip_hits (skip_hits)
`ifdef CSA_OVERFLOW_EN
        ,
        .ovf       (ovf_o)
`endif
    );

`ifndef CSA_OVERFLOW_EN
    assign ovf_o = 1'b0;
`endif

    assign obs = {11'b0, ovf_o, sum, cout, skip_hits};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
        logic [16:0] full;
        logic [15:0] x;
        logic [2:0]  hits;
        logic        v;
        full = {1'b0, ma} + {1'b0, mb} + {16'b0, mc};
        x    = ma ^ mb;
        hits = 3'd0;
        for (int k = 0; k < 4; k++)
            if (x[k*4 +: 4] == 4'hF) hits = hits + 3'd1;
`ifdef CSA_OVERFLOW_EN
        v = (ma[15] == mb[15]) && (full[15] != ma[15]);
`else
        v = 1'b0;
`endif
        return {11'b0, v, full[15:0], full[16], hits};
    endfunction

    // scoreboard: push on accept, pop and compare on result handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    check("sb_result", obs, exp_q.pop_front());
                end
                rx_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one operand set until it is accepted (bounded)
    task automatic drive(input logic [15:0] da, input logic [15:0] db, input logic dc);
        int guard;
        guard    = 0;
        a        = da;
        b        = db;
        cin      = dc;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("drive_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int accepted;
        int rx0;
        logic [15:0] va[3];
        logic [15:0] vb[3];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", obs, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // 1: all blocks skip, latency 2
        out_ready = 1'b1;
        drive(16'hFFFF, 16'h0000, 1'b1);
        check("t1_valid_after_1", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid_after_2", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(sum), 32'h0000);
        check("t1_cout", 32'(cout), 32'd1);
        check("t1_hits", 32'(skip_hits), 32'd4);
`ifdef CSA_OVERFLOW_EN
        check("t1_ovf", 32'(ovf_o), 32'd0);
`endif

        // 2: no skips
        drive(16'h1234, 16'h4321, 1'b0);
        tick();
        check("t2_sum", 32'(sum), 32'h5555);
        check("t2_cout", 32'(cout), 32'd0);
        check("t2_hits", 32'(skip_hits), 32'd0);

        // 3: signed overflow boundaries
        drive(16'h7FFF, 16'h0001, 1'b0);
        tick();
        check("t3a_sum", 32'(sum), 32'h8000);
        check("t3a_cout", 32'(cout), 32'd0);
        check("t3a_hits", 32'(skip_hits), 32'd2);
`ifdef CSA_OVERFLOW_EN
        check("t3a_ovf", 32'(ovf_o), 32'd1);
`endif
        drive(16'h8000, 16'h8000, 1'b0);
        tick();
        check("t3b_sum", 32'(sum), 32'h0000);
        check("t3b_cout", 32'(cout), 32'd1);
        check("t3b_hits", 32'(skip_hits), 32'd0);
`ifdef CSA_OVERFLOW_EN
        check("t3b_ovf", 32'(ovf_o), 32'd1);
`endif
        drain(10);

        // 4: back-pressure, 3 offers with out_ready low
        va = '{16'h0F0F, 16'hABCD, 16'h00FF};
        vb = '{16'h0101, 16'h1111, 16'hFF00};
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 3; i++) begin
            a        = va[i];
            b        = vb[i];
            cin      = 1'b1;
            in_valid = 1'b1;
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("t4_accepted", 32'(accepted), 32'd2);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_value", obs, model(va[0], vb[0], 1'b1));
            tick();
        end
        out_ready = 1'b1;
        drive(va[2], vb[2], 1'b1);
        drain(10);

        // 5: full-rate random stream
        rx0 = rx_cnt;
        for (int i = 0; i < 100; i++) begin
            a        = 16'($urandom_range(0, 16'hFFFF));
            b        = 16'($urandom_range(0, 16'hFFFF));
            cin      = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            check("t5_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) check("t5_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        drain(10);
        check("t5_count", 32'(rx_cnt - rx0), 32'd100);

        // 6: reset with both stages full
        out_ready = 1'b0;
        drive(16'h1111, 16'h2222, 1'b0);
        drive(16'h3333, 16'h4444, 1'b1);
        check("t6_full_valid", 32'(out_valid), 32'd1);
        check("t6_full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_outputs", obs, 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        rx0       = rx_cnt;
        for (int i = 0; i < 5; i++) begin
            check("t6_no_stale", 32'(out_valid), 32'd0);
            tick();
        end
        check("t6_rx_none", 32'(rx_cnt - rx0), 32'd0);

        drive(16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        check("t6_after_sum", 32'(sum), 32'hFFFF);
        check("t6_after_cout", 32'(cout), 32'd1);
        check("t6_after_hits", 32'(skip_hits), 32'd0);
        drain(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
